// File: rtl/sobel_threshold_ctrl.sv
// Adaptive gradient threshold for the Sobel edge stage.
// Counts edge pixels per frame and steps the threshold at frame end.
module sobel_threshold_ctrl #(
    parameter int unsigned CNT_W       = 22,
    parameter int unsigned TH_W        = 21,
    parameter int unsigned TH_INIT     = 10000,
    parameter int unsigned TH_MIN      = 1,
    parameter int unsigned TH_MAX      = (1 << 21) - 1,
    parameter int unsigned STEP_FINE   = 256,
    parameter int unsigned STEP_COARSE = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sobel_vs,
    input  logic             sobel_de,
    input  logic             sobel_data,
    input  logic [CNT_W-1:0] target_lo,
    input  logic [CNT_W-1:0] target_hi,
    input  logic             manual_en,
    input  logic [TH_W-1:0]  manual_th,
    output logic [TH_W-1:0]  threshold,
    output logic [CNT_W-1:0] edge_count,
    output logic             frame_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_EVAL,
        S_APPLY
    } state_e;

    localparam logic [TH_W:0]   MIN_X    = (TH_W+1)'(TH_MIN);
    localparam logic [TH_W:0]   MAX_X    = (TH_W+1)'(TH_MAX);
    localparam logic [TH_W:0]   FINE_X   = (TH_W+1)'(STEP_FINE);
    localparam logic [TH_W:0]   COARSE_X = (TH_W+1)'(STEP_COARSE);
    localparam logic [TH_W-1:0] MIN_T    = TH_W'(TH_MIN);
    localparam logic [TH_W-1:0] MAX_T    = TH_W'(TH_MAX);
    localparam logic [TH_W-1:0] INIT_T   = TH_W'(TH_INIT);

    state_e           state_q, state_d;
    logic             vs_q;
    logic             rise, fall;
    logic             cnt_clr, cnt_en, th_latch, apply;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TH_W-1:0]  th_q, th_next_q, th_calc;
    logic [CNT_W-1:0] ec_q;
    logic             fd_q;

    logic [CNT_W:0]   cnt_x, hi2_x;
    logic [TH_W:0]    th_x, man_x, step_up, step_dn, sum_x, floor_x;

    assign rise = sobel_vs & ~vs_q;
    assign fall = ~sobel_vs & vs_q;

    // Frame-valid delay for edge detection; reset high so a frame
    // already running at reset release never looks like a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vs_q <= 1'b1;
        else        vs_q <= sobel_vs;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; rises outside IDLE are dropped on purpose.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (rise) state_d = S_ACTIVE;
            S_ACTIVE: if (fall) state_d = S_EVAL;
            S_EVAL:   state_d = S_APPLY;
            S_APPLY:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Per-state control strobes.
    always_comb begin
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        th_latch = 1'b0;
        apply    = 1'b0;
        unique case (state_q)
            S_IDLE:   cnt_clr  = rise;
            S_ACTIVE: cnt_en   = sobel_vs & sobel_de & ~sobel_data;
            S_EVAL:   th_latch = 1'b1;
            S_APPLY:  apply    = 1'b1;
            default:  ;
        endcase
    end

    // Saturating edge counter next value.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = '0;
        else if (cnt_en && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    // Edge counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Threshold update rule, evaluated with one extra bit of headroom.
    always_comb begin
        cnt_x   = {1'b0, cnt_q};
        hi2_x   = {target_hi, 1'b0};
        th_x    = {1'b0, th_q};
        man_x   = {1'b0, manual_th};
        step_up = (cnt_x > hi2_x) ? COARSE_X : FINE_X;
        step_dn = (cnt_q < (target_lo >> 1)) ? COARSE_X : FINE_X;
        sum_x   = th_x + step_up;
        floor_x = step_dn + MIN_X;
        th_calc = th_q;
        if (manual_en) begin
            if (man_x < MIN_X)      th_calc = MIN_T;
            else if (man_x > MAX_X) th_calc = MAX_T;
            else                    th_calc = manual_th;
        end else if (cnt_q > target_hi) begin
            if (sum_x > MAX_X) th_calc = MAX_T;
            else               th_calc = sum_x[TH_W-1:0];
        end else if (cnt_q < target_lo) begin
            if (th_x < floor_x) th_calc = MIN_T;
            else                th_calc = th_q - step_dn[TH_W-1:0];
        end
    end

    // Latch the computed threshold in EVAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        th_next_q <= INIT_T;
        else if (th_latch) th_next_q <= th_calc;
    end

    // Publish threshold and count together, with a one-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            th_q <= INIT_T;
            ec_q <= '0;
            fd_q <= 1'b0;
        end else begin
            fd_q <= apply;
            if (apply) begin
                th_q <= th_next_q;
                ec_q <= cnt_q;
            end
        end
    end

    assign threshold  = th_q;
    assign edge_count = ec_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_sobel_threshold_ctrl.sv
// Directed checks for sobel_threshold_ctrl.
// Frames are 32 pixels; target window 4..10.
module tb_sobel_threshold_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vs, de, data;
    logic [21:0] t_lo, t_hi;
    logic        manual_en;
    logic [20:0] manual_th;
    logic [20:0] threshold, th4;
    logic [21:0] edge_count;
    logic [3:0]  ec4;
    logic        frame_done, fd4;

    int total = 0;
    int bad = 0;
    int fd_total = 0;
    int seen, at, th2, c0;

    always #5 clk = ~clk;

    sobel_threshold_ctrl u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sobel_vs   (vs),
        .sobel_de   (de),
        .sobel_data (data),
        .target_lo  (t_lo),
        .target_hi  (t_hi),
        .manual_en  (manual_en),
        .manual_th  (manual_th),
        .threshold  (threshold),
        .edge_count (edge_count),
        .frame_done (frame_done)
    );

    sobel_threshold_ctrl #(.CNT_W(4)) u_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .sobel_vs   (vs),
        .sobel_de   (de),
        .sobel_data (data),
        .target_lo  (4'd4),
        .target_hi  (4'd10),
        .manual_en  (manual_en),
        .manual_th  (manual_th),
        .threshold  (th4),
        .edge_count (ec4),
        .frame_done (fd4)
    );

    always @(posedge clk) if (frame_done) fd_total <= fd_total + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic pixels(input int ne, input int man_at,
                          input logic [20:0] mv);
        @(negedge clk);
        vs = 1'b1; de = 1'b0; data = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            de   = 1'b1;
            data = (i < ne) ? 1'b0 : 1'b1;
            if (i == man_at) begin
                manual_en = 1'b1;
                manual_th = mv;
            end
        end
    endtask

    task automatic tail(output int s, output int a, output int t2);
        @(negedge clk);
        vs = 1'b0; de = 1'b0; data = 1'b1;
        s = 0; a = 0; t2 = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 2) t2 = int'(threshold);
            if (frame_done) begin
                s++;
                a = k;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        vs = 1'b1; de = 1'b1; data = 1'b0;
        t_lo = 22'd4; t_hi = 22'd10;
        manual_en = 1'b0; manual_th = '0;
        repeat (3) @(negedge clk);
        chk("rst_th", 32'(threshold), 10000);
        chk("rst_ec", 32'(edge_count), 0);
        chk("rst_fd", 32'(frame_done), 0);

        // release mid-frame, 12 edges remain
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        tail(seen, at, th2);
        chk("mid_seen", 32'(seen), 0);
        chk("mid_th", 32'(threshold), 10000);
        chk("mid_ec", 32'(edge_count), 0);

        pixels(20, -1, '0);
        tail(seen, at, th2);
        chk("fine_seen", 32'(seen), 1);
        chk("fine_lat", 32'(at), 3);
        chk("fine_pre", 32'(th2), 10000);
        chk("fine_th", 32'(threshold), 10256);
        chk("fine_ec", 32'(edge_count), 20);
        chk("sat_ec", 32'(ec4), 15);

        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_th", 32'(threshold), 10000);
        chk("rst2_ec", 32'(edge_count), 0);
        rst_n = 1'b1;

        pixels(25, -1, '0);
        tail(seen, at, th2);
        chk("coarse_th", 32'(threshold), 14096);
        chk("coarse_ec", 32'(edge_count), 25);

        manual_en = 1'b1; manual_th = 21'd3000;
        pixels(5, -1, '0);
        tail(seen, at, th2);
        chk("man3k_th", 32'(threshold), 3000);
        manual_en = 1'b0;

        pixels(1, -1, '0);
        tail(seen, at, th2);
        chk("clamp_th", 32'(threshold), 1);
        chk("clamp_ec", 32'(edge_count), 1);

        pixels(9, 16, 21'd5000);
        tail(seen, at, th2);
        chk("man_pre", 32'(th2), 1);
        chk("man_th", 32'(threshold), 5000);
        manual_en = 1'b0;

        pixels(3, -1, '0);
        tail(seen, at, th2);
        chk("fdec_th", 32'(threshold), 4744);

        pixels(7, -1, '0);
        tail(seen, at, th2);
        chk("hold_th", 32'(threshold), 4744);
        chk("hold_ec", 32'(edge_count), 7);

        // two-clock blanking: the second frame is skipped
        c0 = fd_total;
        pixels(7, -1, '0);
        @(negedge clk); vs = 1'b0; de = 1'b0; data = 1'b1;
        @(negedge clk);
        pixels(20, -1, '0);
        tail(seen, at, th2);
        chk("skip_seen", 32'(seen), 0);
        chk("skip_pulses", 32'(fd_total - c0), 1);
        chk("skip_th", 32'(threshold), 4744);
        chk("skip_ec", 32'(edge_count), 7);

        pixels(3, -1, '0);
        tail(seen, at, th2);
        chk("after_seen", 32'(seen), 1);
        chk("after_th", 32'(threshold), 4488);
        chk("after_ec", 32'(edge_count), 3);

        manual_en = 1'b1; manual_th = 21'd2097000;
        pixels(5, -1, '0);
        tail(seen, at, th2);
        manual_en = 1'b0;
        pixels(25, -1, '0);
        tail(seen, at, th2);
        chk("max_th", 32'(threshold), 2097151);

        manual_en = 1'b1; manual_th = 21'd0;
        pixels(5, -1, '0);
        tail(seen, at, th2);
        chk("man0_th", 32'(threshold), 1);
        manual_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
